// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared definitions for the BRAM-backed FIFO controller: output buffer
// state encoding and helpers deriving the occupancy counter width and
// buffer fill level.
package bram_fifo_ctrl_pkg;

  // Fill state of the 2-entry output buffer that sits after the RAM.
  typedef enum logic [1:0] {
    OBUF_EMPTY = 2'd0,
    OBUF_ONE   = 2'd1,
    OBUF_TWO   = 2'd2
  } obuf_state_e;

  // Occupancy counter width: DEPTH RAM words + 1 in flight + 2 buffered.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

  // Number of words held in the output buffer for a given state.
  function automatic logic [1:0] obuf_level(input obuf_state_e s);
    logic [1:0] lvl;
    case (s)
      OBUF_ONE: lvl = 2'd1;
      OBUF_TWO: lvl = 2'd2;
      default:  lvl = 2'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// 2-entry first-word-fall-through output buffer fed by RAM read data.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   cap_valid, cap_data  - word returning from the RAM this cycle
//   pop                  - consumer takes the head word this cycle
//   obuf_state           - registered fill state (EMPTY/ONE/TWO)
//   rd_valid, rd_data    - head word presented to the consumer
module fifo_out_skid
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_valid,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  pop,
  output obuf_state_e           obuf_state,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);

  obuf_state_e           state_q, state_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= OBUF_EMPTY;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Data entries need no reset; validity is carried by the state.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  // Next state and entry movement; head is always the oldest word.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      OBUF_EMPTY: begin
        if (cap_valid) begin
          state_d = OBUF_ONE;
          head_d  = cap_data;
        end
      end
      OBUF_ONE: begin
        if (cap_valid && pop) begin
          head_d = cap_data;
        end else if (cap_valid) begin
          state_d = OBUF_TWO;
          tail_d  = cap_data;
        end else if (pop) begin
          state_d = OBUF_EMPTY;
        end
      end
      OBUF_TWO: begin
        // Prefetch throttling keeps a capture from arriving here without a pop.
        if (pop) begin
          head_d = tail_q;
          if (cap_valid) begin
            tail_d = cap_data;
          end else begin
            state_d = OBUF_ONE;
          end
        end
      end
      default: state_d = OBUF_EMPTY;
    endcase
    rd_valid_d = (state_d != OBUF_EMPTY);
  end

  assign obuf_state = state_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = head_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external 1-cycle-latency dual-port RAM with a
// 2-entry FWFT output buffer.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   wr_valid, wr_ready, wr_data     - push handshake
//   rd_valid, rd_ready, rd_data     - first-word-fall-through pop handshake
//   count                           - total words held (registered)
//   ram_ena/wea/addra/dia           - RAM write port A
//   ram_enb/web/addrb, ram_dob      - RAM read port B
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [DATA_WIDTH-1:0]               wr_data,
  output logic                                rd_valid,
  input  logic                                rd_ready,
  output logic [DATA_WIDTH-1:0]               rd_data,
  output logic [cnt_width(ADDR_WIDTH)-1:0]    count,
  output logic                                ram_ena,
  output logic                                ram_wea,
  output logic [ADDR_WIDTH-1:0]               ram_addra,
  output logic [DATA_WIDTH-1:0]               ram_dia,
  output logic                                ram_enb,
  output logic                                ram_web,
  output logic [ADDR_WIDTH-1:0]               ram_addrb,
  input  logic [DATA_WIDTH-1:0]               ram_dob
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned RC_W  = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [RC_W-1:0]       ram_cnt_q, ram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  wr_ready_q, wr_ready_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  push;
  logic                  pop;
  logic                  prefetch;
  logic [1:0]            obuf_lvl;
  logic [1:0]            obuf_lvl_next;
  obuf_state_e           obuf_state;

  // Pointer, occupancy and handshake registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      inflight_q <= inflight_d;
      wr_ready_q <= wr_ready_d;
      count_q    <= count_d;
    end
  end

  // Push/pop qualification, prefetch decision and next-state arithmetic.
  always_comb begin
    obuf_lvl = obuf_level(obuf_state);
    push     = rst_n & wr_valid & wr_ready_q;
    pop      = rd_valid & rd_ready;
    // Buffer level after this edge: the in-flight word lands, a pop leaves.
    obuf_lvl_next = obuf_lvl + 2'(inflight_q) - 2'(pop);
    // Only fetch when the word returning next cycle is guaranteed a slot.
    prefetch = rst_n && (ram_cnt_q != '0) && (obuf_lvl_next <= 2'd1);

    wr_ptr_d   = push     ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = prefetch ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    ram_cnt_d  = ram_cnt_q + RC_W'(push) - RC_W'(prefetch);
    inflight_d = prefetch;
    wr_ready_d = (ram_cnt_d != RC_W'(DEPTH));
    count_d    = CNT_W'(ram_cnt_d) + CNT_W'(inflight_d) + CNT_W'(obuf_lvl_next);
  end

  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .cap_valid (inflight_q),
    .cap_data  (ram_dob),
    .pop       (pop),
    .obuf_state(obuf_state),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  // RAM strobes are same-cycle with the accepted push / issued prefetch.
  assign ram_ena   = push;
  assign ram_wea   = push;
  assign ram_addra = wr_ptr_q;
  assign ram_dia   = wr_data;
  assign ram_enb   = prefetch;
  assign ram_web   = 1'b0;
  assign ram_addrb = rd_ptr_q;

  assign wr_ready  = wr_ready_q;
  assign count     = count_q;

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Self-checking bench for bram_fifo_ctrl with a queue-based reference model.
module tb_bram_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic [AW+1:0] count;
  logic          ram_ena, ram_wea, ram_enb, ram_web;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia, ram_dob;

  int checks   = 0;
  int failures = 0;

  bram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External RAM: 1-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) mem[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= mem[ram_addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words as queues (RAM, in flight, output buffer).
  logic [DW-1:0] m_ram[$];
  logic [DW-1:0] m_obuf[$];
  bit            m_flight;
  logic [DW-1:0] m_fword;
  bit            m_wr_ready;
  bit            m_init;
  int            m_wptr, m_rptr;

  initial begin : compare
    bit s_rst, e_push, e_pop, e_pf;
    logic [DW-1:0] s_wd;
    m_flight = 0; m_wr_ready = 0; m_init = 0; m_wptr = 0; m_rptr = 0;
    forever begin
      @(negedge clk);
      s_rst  = rst_n;
      s_wd   = wr_data;
      e_pop  = s_rst && rd_ready && (m_obuf.size() > 0);
      e_push = s_rst && wr_valid && m_wr_ready;
      e_pf   = s_rst && (m_ram.size() != 0) &&
               (m_obuf.size() + (m_flight ? 1 : 0) - (e_pop ? 1 : 0) <= 1);
      if (m_init) begin
        chk("m_rd_valid", 32'(rd_valid), 32'(m_obuf.size() > 0));
        if (m_obuf.size() > 0) chk("m_rd_data", 32'(rd_data), 32'(m_obuf[0]));
        chk("m_count", 32'(count), 32'(m_ram.size() + (m_flight ? 1 : 0) + m_obuf.size()));
        chk("m_wr_ready", 32'(wr_ready), 32'(m_wr_ready));
        chk("m_ram_ena", 32'(ram_ena), 32'(e_push));
        chk("m_ram_wea", 32'(ram_wea), 32'(e_push));
        if (e_push) begin
          chk("m_ram_addra", 32'(ram_addra), 32'(m_wptr));
          chk("m_ram_dia", 32'(ram_dia), 32'(s_wd));
        end
        chk("m_ram_enb", 32'(ram_enb), 32'(e_pf));
        if (e_pf) chk("m_ram_addrb", 32'(ram_addrb), 32'(m_rptr));
        chk("m_ram_web", 32'(ram_web), 32'(0));
      end
      @(posedge clk);
      if (!s_rst) begin
        m_ram.delete(); m_obuf.delete();
        m_flight = 0; m_wptr = 0; m_rptr = 0;
        m_wr_ready = 0; m_init = 1;
      end else begin
        if (e_pop) void'(m_obuf.pop_front());
        if (m_flight) m_obuf.push_back(m_fword);
        m_flight = e_pf;
        if (e_pf) begin
          m_fword = m_ram.pop_front();
          m_rptr  = (m_rptr + 1) % DEPTH;
        end
        if (e_push) begin
          m_ram.push_back(s_wd);
          m_wptr = (m_wptr + 1) % DEPTH;
        end
        m_wr_ready = (m_ram.size() != DEPTH);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int acc, pops, seq;
    logic [DW-1:0] sbq[$];
    logic [31:0] exp_w;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) step();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_wr_ready", 32'(wr_ready), 32'(0));
    rst_n = 1'b1;
    step();
    chk("rst_rel_wr_ready", 32'(wr_ready), 32'(1));

    // Single word latency.
    wr_valid = 1'b1; wr_data = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("lat_n0_valid", 32'(rd_valid), 32'(0));
    step();
    chk("lat_n1_valid", 32'(rd_valid), 32'(0));
    step();
    chk("lat_n2_valid", 32'(rd_valid), 32'(1));
    chk("lat_n2_data", 32'(rd_data), 32'(8'hA5));
    chk("lat_n2_count", 32'(count), 32'(1));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("lat_pop_valid", 32'(rd_valid), 32'(0));
    chk("lat_pop_count", 32'(count), 32'(0));

    // Fill with 0x01..0x08 while stalled.
    acc = 0;
    for (int v = 1; v <= 8; v++) begin
      wr_valid = 1'b1; wr_data = 8'(v);
      if (wr_ready) acc++;
      step();
    end
    wr_valid = 1'b0;
    step(); step();
    chk("full_accepted", 32'(acc), 32'(6));
    chk("full_wr_ready", 32'(wr_ready), 32'(0));
    chk("full_count", 32'(count), 32'(6));
    chk("full_rd_data", 32'(rd_data), 32'(8'h01));

    // Drain from full on consecutive cycles.
    rd_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      chk("drain_valid", 32'(rd_valid), 32'(1));
      chk("drain_data", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    chk("drain_end_valid", 32'(rd_valid), 32'(0));
    chk("drain_end_count", 32'(count), 32'(0));

    // Continuous streaming: one in and one out per cycle.
    rd_ready = 1'b1; wr_valid = 1'b1; seq = 8'h40;
    repeat (3) begin
      wr_data = 8'(seq); seq++;
      step();
    end
    for (int k = 0; k < 20; k++) begin
      wr_data = 8'(seq); seq++;
      chk("stream_count", 32'(count), 32'(3));
      chk("stream_valid", 32'(rd_valid), 32'(1));
      chk("stream_data", 32'(rd_data), 32'(8'h40 + k));
      step();
    end
    wr_valid = 1'b0;
    repeat (6) step();
    rd_ready = 1'b0;
    chk("stream_end_count", 32'(count), 32'(0));
    chk("stream_end_valid", 32'(rd_valid), 32'(0));

    // Random backpressure over 100 words.
    acc = 0; pops = 0;
    for (int cyc = 0; cyc < 3000 && (acc < 100 || pops < 100); cyc++) begin
      wr_valid = (acc < 100) && ($urandom_range(0, 3) != 0);
      wr_data  = 8'($urandom);
      rd_ready = 1'($urandom_range(0, 1));
      if (rd_valid && rd_ready) begin
        pops++;
        exp_w = (sbq.size() > 0) ? 32'(sbq.pop_front()) : 32'hDEAD;
        chk("rand_order", 32'(rd_data), exp_w);
      end
      if (wr_valid && wr_ready) begin
        acc++;
        sbq.push_back(wr_data);
      end
      step();
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    chk("rand_pops", 32'(pops), 32'(100));
    chk("rand_sb_left", 32'(sbq.size()), 32'(0));
    step(); step();

    // Reset mid-operation with 5 words held.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    wr_valid = 1'b0;
    repeat (3) step();
    chk("mid_count", 32'(count), 32'(5));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(count), 32'(0));
    chk("mid_rst_valid", 32'(rd_valid), 32'(0));
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'(0));
    step();
    chk("mid_rel_wr_ready", 32'(wr_ready), 32'(1));
    wr_valid = 1'b1; wr_data = 8'h3C;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 10 && !rd_valid; i++) step();
    chk("mid_first_valid", 32'(rd_valid), 32'(1));
    chk("mid_first_data", 32'(rd_data), 32'(8'h3C));
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
